// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: state encoding,
// soft-reset counter sizing, default parameters and a saturating increment.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ASSERT = 2'd0,
      HOLD   = 2'd1,
      RUN    = 2'd2
   } state_t;

   localparam int                    SOFT_COUNT_W   = 9;
   localparam logic [SOFT_COUNT_W-1:0] SOFT_COUNT_MAX = 9'd511;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_HOLD_CYCLES = 16;
   localparam int DEF_WDOG_CYCLES = 1024;

   function automatic logic [SOFT_COUNT_W-1:0] sat_inc(input logic [SOFT_COUNT_W-1:0] value);
      if (value == SOFT_COUNT_MAX) begin
         return value;
      end else begin
         return value + 9'd1;
      end
   endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// Reset deassertion synchronizer: a chain of flops shifting in a constant 1,
// cleared asynchronously by the raw active-low reset.
module reset_sync
   import reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
)(
   input  logic clock,
   input  logic reset,
   output logic synced
);

   logic [SYNC_STAGES-1:0] chain_r;

   // shift register: asynchronous clear, synchronous fill with ones
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         chain_r <= '0;
      end else begin
         chain_r <= {chain_r[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign synced = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer top: ASSERT/HOLD/RUN FSM, hold counter, soft-reset counter.
// Optional watchdog compiled in with RESET_SEQ_WDOG_EN.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    sw_req,
   input  logic                    kick,
   output logic                    rst_n_out,
   output logic                    rst_out,
   output logic                    busy,
   output logic                    done,
   output logic [SOFT_COUNT_W-1:0] soft_count,
   output logic                    wdog_fired
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   state_t                  state_r, state_s;
   logic [HOLD_W-1:0]       hold_cnt_r, hold_cnt_s;
   logic [SOFT_COUNT_W-1:0] soft_count_r, soft_count_s;
   logic                    fired_r, fired_s;
   logic                    rst_n_r, rst_r, busy_r, done_r;
   logic                    synced_s;
   logic                    expire_s;

   reset_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clock  (clock),
      .reset  (reset),
      .synced (synced_s)
   );

`ifdef RESET_SEQ_WDOG_EN
   localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

   logic [WDOG_W-1:0] wdog_cnt_r, wdog_cnt_s;

   // expiry is only meaningful while running; a kick on the last cycle rescues it
   always_comb begin
      expire_s = (state_r == RUN) && (wdog_cnt_r == WDOG_LAST) && !kick;
   end

   // counter runs only while staying in RUN, so every HOLD entry clears it
   always_comb begin
      wdog_cnt_s = '0;
      if ((state_r == RUN) && (state_s == RUN)) begin
         if (kick) begin
            wdog_cnt_s = '0;
         end else begin
            wdog_cnt_s = wdog_cnt_r + WDOG_W'(1);
         end
      end else begin
         wdog_cnt_s = '0;
      end
   end

   // watchdog counter register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wdog_cnt_r <= '0;
      end else begin
         wdog_cnt_r <= wdog_cnt_s;
      end
   end
`else
   logic unused_wdog_s;

   assign unused_wdog_s = kick | (WDOG_CYCLES < 1);
   assign expire_s      = 1'b0;
`endif

   // next-state, hold counter and soft-reset bookkeeping
   always_comb begin
      state_s      = state_r;
      hold_cnt_s   = hold_cnt_r;
      soft_count_s = soft_count_r;
      fired_s      = fired_r;
      case (state_r)
         ASSERT: begin
            if (synced_s) begin
               state_s    = HOLD;
               hold_cnt_s = '0;
            end else begin
               state_s    = ASSERT;
            end
         end
         HOLD: begin
            if (hold_cnt_r == HOLD_LAST) begin
               state_s    = RUN;
               hold_cnt_s = '0;
            end else begin
               hold_cnt_s = hold_cnt_r + HOLD_W'(1);
            end
         end
         RUN: begin
            if (sw_req || expire_s) begin
               state_s      = HOLD;
               hold_cnt_s   = '0;
               soft_count_s = sat_inc(soft_count_r);
               fired_s      = fired_r | expire_s;
            end else begin
               state_s      = RUN;
            end
         end
         default: begin
            state_s    = ASSERT;
            hold_cnt_s = '0;
         end
      endcase
   end

   // state and outputs are all flops; outputs derive from the next state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= ASSERT;
         hold_cnt_r   <= '0;
         soft_count_r <= '0;
         fired_r      <= 1'b0;
         rst_n_r      <= 1'b0;
         rst_r        <= 1'b1;
         busy_r       <= 1'b1;
         done_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         hold_cnt_r   <= hold_cnt_s;
         soft_count_r <= soft_count_s;
         fired_r      <= fired_s;
         rst_n_r      <= (state_s == RUN);
         rst_r        <= (state_s != RUN);
         busy_r       <= (state_s != RUN);
         done_r       <= (state_s == RUN) && (state_r != RUN);
      end
   end

   assign rst_n_out  = rst_n_r;
   assign rst_out    = rst_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign soft_count = soft_count_r;
   assign wdog_fired = fired_r;

endmodule
